// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet destination, steers FSM write strobes to one
// of NUM_CH output FIFOs, and runs a per-channel watchdog that soft-resets stalled FIFOs.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] valid_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("router_sync_n: NUM_CH must be in 2..16");
  end
  if ((1 << ADDR_W) < NUM_CH) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow for NUM_CH");
  end
  if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W)) begin : g_bad_timeout
    $error("router_sync_n: TIMEOUT must be in 2..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_CH;
  endfunction

  function automatic logic [NUM_CH-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_CH-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) d[i] = (a == ADDR_W'(i));
    return d;
  endfunction

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_ok_q, addr_ok_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sr_q, sr_d;
  logic [NUM_CH-1:0] sel;

  // Address latch: the new destination only steers writes from the next cycle on.
  always_comb begin
    addr_d     = addr_q;
    addr_ok_d  = addr_ok_q;
    addr_err_d = 1'b0;
    if (detect_add) begin
      addr_d     = data_in;
      addr_ok_d  = addr_valid(data_in);
      addr_err_d = ~addr_valid(data_in);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_ok_q  <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_ok_q  <= addr_ok_d;
      addr_err_q <= addr_err_d;
    end
  end

  // An invalid address gates both the strobe and the full flag so the FSM drains the packet.
  always_comb begin
    sel       = decode(addr_q);
    write_enb = (write_enb_reg && addr_ok_q) ? sel : '0;
    fifo_full = addr_ok_q & (|(full & sel));
    valid_out = ~empty;
  end

  // Watchdog: counts consecutive cycles with data present and no read.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      sr_d[i]  = 1'b0;
      if (!(empty[i] || read_enb[i])) begin
        if (cnt_q[i] == CNT_MAX) sr_d[i] = 1'b1;
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      sr_q <= sr_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign soft_reset = sr_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_router_sync_n;
  localparam int NUM_CH = 3, ADDR_W = 2, TIMEOUT = 30, CNT_W = 5;

  logic              clock = 1'b0;
  logic              resetn;
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb, empty, full;
  logic [NUM_CH-1:0] write_enb, valid_out, soft_reset;
  logic              fifo_full, addr_err;

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .write_enb(write_enb), .fifo_full(fifo_full), .valid_out(valid_out),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [2:0] sr;
    logic       err;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vo;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int c, input logic [2:0] act, input logic [2:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", nm, c, act, req);
    end
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic step(input logic [2:0] sr, input logic err, input logic [2:0] we, input logic ff);
    exp_t e;
    e.cyc = cyc;
    e.sr  = sr;
    e.err = err;
    e.we  = we;
    e.ff  = ff;
    e.vo  = ~empty;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("soft_reset", m_e.cyc, soft_reset, m_e.sr);
      chk("addr_err",   m_e.cyc, {2'b00, addr_err}, {2'b00, m_e.err});
      chk("write_enb",  m_e.cyc, write_enb, m_e.we);
      chk("fifo_full",  m_e.cyc, {2'b00, fifo_full}, {2'b00, m_e.ff});
      chk("valid_out",  m_e.cyc, valid_out, m_e.vo);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    read_enb = '0; empty = 3'b111; full = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state: address 0 valid, no pulses
    write_enb_reg = 1'b1; full = 3'b001;
    step(3'b000, 1'b0, 3'b001, 1'b1);
    write_enb_reg = 1'b0; full = 3'b000; resetn = 1'b1;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 1: latch address 2; same-cycle write still uses old address
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b1; full = 3'b100;
    step(3'b000, 1'b0, 3'b001, 1'b0);
    detect_add = 1'b0;
    step(3'b000, 1'b0, 3'b100, 1'b1);
    full = 3'b000;
    step(3'b000, 1'b0, 3'b100, 1'b0);
    write_enb_reg = 1'b0; full = 3'b100;
    step(3'b000, 1'b0, 3'b000, 1'b1);

    // Test 2: out-of-range address 3
    detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b1; full = 3'b111;
    step(3'b000, 1'b0, 3'b100, 1'b1);
    detect_add = 1'b0;
    step(3'b000, 1'b1, 3'b000, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0);
    detect_add = 1'b1; data_in = 2'd0;
    step(3'b000, 1'b0, 3'b000, 1'b0);
    detect_add = 1'b0;
    step(3'b000, 1'b0, 3'b001, 1'b1);
    write_enb_reg = 1'b0; full = 3'b000;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 3: channel 1 stalled, pulses in cycles 31 and 61
    empty = 3'b101;
    for (int k = 1; k <= 62; k++) step((k == 31 || k == 61) ? 3'b010 : 3'b000, 1'b0, 3'b000, 1'b0);
    empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 4: read at cycle 29 restarts the count; pulse at cycle 60
    empty = 3'b101;
    for (int k = 1; k <= 61; k++) begin
      read_enb = (k == 29) ? 3'b010 : 3'b000;
      step((k == 60) ? 3'b010 : 3'b000, 1'b0, 3'b000, 1'b0);
    end
    read_enb = 3'b000; empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 5: channels 0 and 2 stall 5 cycles apart
    for (int k = 1; k <= 40; k++) begin
      empty = {(k < 6), 1'b1, 1'b0};
      step({(k == 36), 1'b0, (k == 31)}, 1'b0, 3'b000, 1'b0);
    end
    empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 6: reset at stalled cycle 20; fresh 30-cycle count, address back to 0
    detect_add = 1'b1; data_in = 2'd2;
    step(3'b000, 1'b0, 3'b000, 1'b0);
    detect_add = 1'b0; write_enb_reg = 1'b1; empty = 3'b101;
    for (int k = 1; k <= 52; k++) begin
      resetn = (k != 20);
      step((k == 51) ? 3'b010 : 3'b000, 1'b0, (k <= 20) ? 3'b100 : 3'b001, 1'b0);
    end
    write_enb_reg = 1'b0; empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 7: reset on the edge that would have pulsed suppresses the pulse
    empty = 3'b101;
    for (int k = 1; k <= 32; k++) begin
      resetn = (k != 30);
      step(3'b000, 1'b0, 3'b000, 1'b0);
    end
    resetn = 1'b1; empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    // Test 8: read during the pulse cycle keeps the pulse, clears the count
    empty = 3'b101;
    for (int k = 1; k <= 63; k++) begin
      read_enb = (k == 31) ? 3'b010 : 3'b000;
      step((k == 31 || k == 62) ? 3'b010 : 3'b000, 1'b0, 3'b000, 1'b0);
    end
    read_enb = 3'b000; empty = 3'b111;
    step(3'b000, 1'b0, 3'b000, 1'b0);

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clock);
      w++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
